// File: rtl/ooc_lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module      : ooc_lfsr_bank
// Description : Multi-channel xorshift32 stimulus source for out-of-context
//               harnesses, with run/burst/hold control, run-time seed loading
//               and an optional output-compaction signature.
//               Optional feature macro: OOC_MISR_EN (signature compaction).
// Revision    : 1.0 - initial release
// ============================================================================
module ooc_lfsr_bank #(
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 32,
    parameter int SEED_BASE = 3,
    parameter int OBS_WIDTH = 64,
    parameter int SIG_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_run,
    input  logic                         start_burst,
    input  logic [15:0]                  burst_len,
    input  logic                         stop,
    input  logic                         seed_wr,
    input  logic [3:0]                   seed_ch,
    input  logic [31:0]                  seed_data,
    output logic [NUM_CH*CH_WIDTH-1:0]   rnd_out,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  adv_count,
    input  logic [OBS_WIDTH-1:0]         obs_in,
    output logic [SIG_WIDTH-1:0]         signature
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] remaining;
    logic [15:0] remaining_nxt;
    logic        done_nxt;
    logic        advance;
    logic [31:0] ch_state [NUM_CH];

    // One xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Next-state decode; stop outranks the start requests, start_run outranks start_burst
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        advance       = 1'b0;
        case (state)
            IDLE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start_run) begin
                    state_nxt = RUN;
                end else if (start_burst) begin
                    if (burst_len == 16'd0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt     = BURST;
                        remaining_nxt = burst_len;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            BURST: begin
                if (stop) begin
                    state_nxt     = IDLE;
                    remaining_nxt = 16'd0;
                end else begin
                    advance       = 1'b1;
                    remaining_nxt = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                remaining_nxt = 16'd0;
            end
        endcase
    end

    // Control state, burst counter, done pulse and advance counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= 16'd0;
            done      <= 1'b0;
            adv_count <= 32'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            done      <= done_nxt;
            if (advance) begin
                adv_count <= adv_count + 32'd1;
            end
        end
    end

    assign busy = (state != IDLE);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            // An all-zero seed would lock the generator, so it is replaced by 1
            localparam logic [31:0] SEED_RAW  = 32'(SEED_BASE + 2 * i);
            localparam logic [31:0] SEED_INIT = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

            logic seed_hit;
            assign seed_hit = seed_wr && (seed_ch == 4'(i));

            // Per-channel generator: seed load takes precedence over advancing
            always_ff @(posedge clk) begin
                if (reset) begin
                    ch_state[i] <= SEED_INIT;
                end else if (seed_hit) begin
                    ch_state[i] <= (seed_data == 32'd0) ? 32'd1 : seed_data;
                end else if (advance) begin
                    ch_state[i] <= xorshift32(ch_state[i]);
                end
            end

            assign rnd_out[i*CH_WIDTH +: CH_WIDTH] = ch_state[i][CH_WIDTH-1:0];
        end
    endgenerate

`ifdef OOC_MISR_EN
    localparam int NUM_CHUNKS = (OBS_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int PAD_WIDTH  = NUM_CHUNKS * SIG_WIDTH;

    logic [PAD_WIDTH-1:0] obs_padded;
    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] sig_r;

    assign obs_padded = PAD_WIDTH'(obs_in);

    // XOR-fold the observed bus into signature-width chunks (last chunk zero-padded)
    always_comb begin
        fold = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            fold = fold ^ obs_padded[c*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    // Rotate-and-fold compaction, active regardless of control state
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_r <= '0;
        end else begin
            sig_r <= {sig_r[SIG_WIDTH-2:0], sig_r[SIG_WIDTH-1]} ^ fold;
        end
    end

    assign signature = sig_r;
`else
    logic obs_unused;
    assign obs_unused = ^obs_in;
    assign signature  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ooc_lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ooc_lfsr_bank
// Description : Self-checking bench for ooc_lfsr_bank (default parameters).
//               Expected outputs are queued when each step is driven and
//               compared one cycle later against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ooc_lfsr_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_run;
    logic         start_burst;
    logic [15:0]  burst_len;
    logic         stop;
    logic         seed_wr;
    logic [3:0]   seed_ch;
    logic [31:0]  seed_data;
    logic [127:0] rnd_out;
    logic         busy;
    logic         done;
    logic [31:0]  adv_count;
    logic [63:0]  obs_in;
    logic [31:0]  signature;

    int errors = 0;
    int checks = 0;
    int busy_seen;
    int done_seen;

    typedef struct {
        logic [127:0] rnd;
        logic         busy;
        logic         done;
        logic [31:0]  cnt;
        logic [31:0]  sig;
    } exp_t;

    exp_t exp_q [$];

    // Reference model state: 0 idle, 1 run, 2 burst
    int          m_fsm;
    int          m_rem;
    logic [31:0] m_st [4];
    logic [31:0] m_cnt;
    logic        m_done;
    logic [31:0] m_sig;

    ooc_lfsr_bank dut (
        .clk         (clk),
        .reset       (reset),
        .start_run   (start_run),
        .start_burst (start_burst),
        .burst_len   (burst_len),
        .stop        (stop),
        .seed_wr     (seed_wr),
        .seed_ch     (seed_ch),
        .seed_data   (seed_data),
        .rnd_out     (rnd_out),
        .busy        (busy),
        .done        (done),
        .adv_count   (adv_count),
        .obs_in      (obs_in),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.rnd  = {m_st[3], m_st[2], m_st[1], m_st[0]};
        e.busy = (m_fsm != 0);
        e.done = m_done;
        e.cnt  = m_cnt;
        e.sig  = m_sig;
        return e;
    endfunction

    task automatic wait_and_compare();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
        end else begin
            e = exp_q.pop_front();
            check("rnd_out",   rnd_out,           e.rnd);
            check("busy",      {127'd0, busy},    {127'd0, e.busy});
            check("done",      {127'd0, done},    {127'd0, e.done});
            check("adv_count", {96'd0, adv_count}, {96'd0, e.cnt});
            check("signature", {96'd0, signature}, {96'd0, e.sig});
        end
        busy_seen += int'(busy);
        done_seen += int'(done);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start_run   = 1'b0;
        start_burst = 1'b0;
        burst_len   = 16'd0;
        stop        = 1'b0;
        seed_wr     = 1'b0;
        seed_ch     = 4'd0;
        seed_data   = 32'd0;
        m_fsm  = 0;
        m_rem  = 0;
        m_cnt  = 32'd0;
        m_done = 1'b0;
        m_sig  = 32'd0;
        for (int i = 0; i < 4; i++) m_st[i] = 32'(3 + 2 * i);
        exp_q.push_back(model_snapshot());
        wait_and_compare();
        reset = 1'b0;
    endtask

    // Drive one cycle of controls, advance the model, queue the expectation
    task automatic step(input logic sr, input logic sb, input logic [15:0] bl,
                        input logic sp, input logic sw, input logic [3:0] sc,
                        input logic [31:0] sd, input logic [63:0] ob);
        logic adv;
        int   fsm_n;
        int   rem_n;
        logic done_n;
        start_run   = sr;
        start_burst = sb;
        burst_len   = bl;
        stop        = sp;
        seed_wr     = sw;
        seed_ch     = sc;
        seed_data   = sd;
        obs_in      = ob;
        adv    = (m_fsm != 0) && !sp;
        fsm_n  = m_fsm;
        rem_n  = m_rem;
        done_n = 1'b0;
        if (m_fsm == 0) begin
            if (!sp && sr) fsm_n = 1;
            else if (!sp && sb) begin
                if (bl == 16'd0) done_n = 1'b1;
                else begin
                    fsm_n = 2;
                    rem_n = int'(bl);
                end
            end
        end else if (sp) begin
            fsm_n = 0;
            rem_n = 0;
        end else if (m_fsm == 2) begin
            rem_n = m_rem - 1;
            if (rem_n == 0) begin
                fsm_n  = 0;
                done_n = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (sw && sc == 4'(i)) m_st[i] = (sd == 32'd0) ? 32'd1 : sd;
            else if (adv) m_st[i] = xs32(m_st[i]);
        end
        if (adv) m_cnt = m_cnt + 32'd1;
`ifdef OOC_MISR_EN
        m_sig = {m_sig[30:0], m_sig[31]} ^ (ob[31:0] ^ ob[63:32]);
`else
        m_sig = 32'd0;
`endif
        m_fsm  = fsm_n;
        m_rem  = rem_n;
        m_done = done_n;
        exp_q.push_back(model_snapshot());
        wait_and_compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 16'd0, 0, 0, 4'd0, 32'd0, 64'd1);
    endtask

    initial begin
        obs_in = 64'd1;

        // Reset values and signature start-up sequence with obs_in = 1
        do_reset();
        check("reset_seeds", rnd_out, {32'd9, 32'd7, 32'd5, 32'd3});
        check("reset_cnt", {96'd0, adv_count}, 128'd0);
        check("reset_busy_done", {126'd0, busy, done}, 128'd0);
        check("reset_sig", {96'd0, signature}, 128'd0);
        idle(1);
`ifdef OOC_MISR_EN
        check("sig_edge1", {96'd0, signature}, 128'd1);
        idle(1);
        check("sig_edge2", {96'd0, signature}, 128'd3);
        idle(1);
        check("sig_edge3", {96'd0, signature}, 128'd7);
`else
        idle(2);
        check("sig_tied_zero", {96'd0, signature}, 128'd0);
`endif

        // Seed ch0 with 1, single run advance, then stop
        do_reset();
        step(0, 0, 16'd0, 0, 1, 4'd0, 32'd1, 64'd1);
        step(1, 0, 16'd0, 0, 0, 4'd0, 32'd0, 64'd1);
        idle(1);
        check("ch0_first_adv", {96'd0, rnd_out[31:0]}, {96'd0, 32'h00042021});
        check("cnt_after_run", {96'd0, adv_count}, 128'd1);
        step(0, 0, 16'd0, 1, 0, 4'd0, 32'd0, 64'd1);
        idle(2);
        check("cnt_after_stop", {96'd0, adv_count}, 128'd1);

        // Burst of 5
        do_reset();
        busy_seen = 0;
        done_seen = 0;
        step(0, 1, 16'd5, 0, 0, 4'd0, 32'd0, 64'd1);
        idle(7);
        check("burst5_busy_cycles", 128'(busy_seen), 128'd5);
        check("burst5_done_pulses", 128'(done_seen), 128'd1);
        check("burst5_cnt", {96'd0, adv_count}, 128'd5);

        // Zero-length burst
        do_reset();
        busy_seen = 0;
        done_seen = 0;
        step(0, 1, 16'd0, 0, 0, 4'd0, 32'd0, 64'd1);
        check("burst0_done_next", {127'd0, done}, 128'd1);
        idle(3);
        check("burst0_busy_cycles", 128'(busy_seen), 128'd0);
        check("burst0_done_pulses", 128'(done_seen), 128'd1);
        check("burst0_cnt", {96'd0, adv_count}, 128'd0);

        // Zero seed into ch2 while running
        do_reset();
        step(1, 0, 16'd0, 0, 0, 4'd0, 32'd0, 64'd1);
        idle(1);
        step(0, 0, 16'd0, 0, 1, 4'd2, 32'd0, 64'd1);
        check("ch2_zero_seed", {96'd0, rnd_out[95:64]}, 128'd1);
        check("seed_run_cnt", {96'd0, adv_count}, 128'd2);
        step(0, 0, 16'd0, 1, 0, 4'd0, 32'd0, 64'd1);

        // Burst of 10 aborted after the third advance
        do_reset();
        busy_seen = 0;
        done_seen = 0;
        step(0, 1, 16'd10, 0, 0, 4'd0, 32'd0, 64'd1);
        idle(3);
        step(0, 0, 16'd0, 1, 0, 4'd0, 32'd0, 64'd1);
        idle(3);
        check("abort_done_pulses", 128'(done_seen), 128'd0);
        check("abort_cnt", {96'd0, adv_count}, 128'd3);
        check("abort_idle", {127'd0, busy}, 128'd0);

        // Reset in the middle of a run
        step(1, 0, 16'd0, 0, 0, 4'd0, 32'd0, 64'd1);
        idle(4);
        do_reset();
        check("midrun_reset_seeds", rnd_out, {32'd9, 32'd7, 32'd5, 32'd3});
        check("midrun_reset_cnt", {96'd0, adv_count}, 128'd0);

        // Randomised mix of controls, seed writes (including out-of-range channels) and obs data
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 16'($urandom_range(0, 6)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 (k % 7 == 0) ? 32'd0 : 32'($urandom),
                 {32'($urandom), 32'($urandom)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
